// File: rtl/isa_fetch_decode_exec_pkg.sv
// Shared widths, opcode constants, instruction layout and ROM boot image.
package isa_fetch_decode_exec_pkg;

    localparam int unsigned INST_SIZE_LOG = 3;
    localparam int unsigned RF_SIZE_LOG   = 2;
    localparam int unsigned REG_LEN       = 4;
    localparam int unsigned MEMI_SIZE_LOG = 3;
    localparam int unsigned MEMD_SIZE_LOG = 2;
    localparam int unsigned INST_LEN      = INST_SIZE_LOG + RF_SIZE_LOG + REG_LEN + RF_SIZE_LOG;
    localparam int unsigned MEMI_SIZE     = 1 << MEMI_SIZE_LOG;

    localparam logic [INST_SIZE_LOG-1:0] INST_OP_NOP = INST_SIZE_LOG'(0);
    localparam logic [INST_SIZE_LOG-1:0] INST_OP_LI  = INST_SIZE_LOG'(1);
    localparam logic [INST_SIZE_LOG-1:0] INST_OP_ADD = INST_SIZE_LOG'(2);
    localparam logic [INST_SIZE_LOG-1:0] INST_OP_MUL = INST_SIZE_LOG'(3);
    localparam logic [INST_SIZE_LOG-1:0] INST_OP_LD  = INST_SIZE_LOG'(4);
    localparam logic [INST_SIZE_LOG-1:0] INST_OP_BR  = INST_SIZE_LOG'(5);

    // ROB entry lifecycle used by the surrounding core.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STALLED  = 2'd1,
        READY    = 2'd2,
        FINISHED = 2'd3
    } rob_state_e;

    // Instruction word layout, MSB first.
    typedef struct packed {
        logic [INST_SIZE_LOG-1:0] op;
        logic [RF_SIZE_LOG-1:0]   rd;
        logic [REG_LEN-1:0]       imm;
        logic [RF_SIZE_LOG-1:0]   rs2;
    } inst_t;

    // Boot program loaded into the instruction ROM on reset.
    function automatic logic [INST_LEN-1:0] rom_word(input int unsigned idx);
        logic [INST_LEN-1:0] w;
        case (idx)
            0:       w = INST_LEN'(11'h148); // LI  r1, 2
            1:       w = INST_LEN'(11'h484); // LD  r2, [r1]
            2:       w = INST_LEN'(11'h2C6); // ADD r3, r1, r2
            3:       w = INST_LEN'(11'h508); // BR  r0==0, +2
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/isa_fetch_decode_exec_if.sv
// Fetch, decode and execute signal bundle between the core and this block.
interface isa_fetch_decode_exec_if;
    import isa_fetch_decode_exec_pkg::*;

    logic [MEMI_SIZE_LOG-1:0] req_addr;
    logic [INST_LEN-1:0]      resp_data;

    logic [INST_SIZE_LOG-1:0] opcode;
    logic                     rs1_used;
    logic [REG_LEN-1:0]       rs1_imm;
    logic [MEMI_SIZE_LOG-1:0] rs1_br_offset;
    logic [RF_SIZE_LOG-1:0]   rs1;
    logic                     rs2_used;
    logic [RF_SIZE_LOG-1:0]   rs2;
    logic                     wen;
    logic [RF_SIZE_LOG-1:0]   rd;
    logic                     rd_data_use_alu;
    logic                     mem_valid;
    logic                     is_br;

    logic [MEMI_SIZE_LOG-1:0] ex_pc;
    logic [INST_SIZE_LOG-1:0] ex_op;
    logic [REG_LEN-1:0]       ex_rs1_imm;
    logic [MEMI_SIZE_LOG-1:0] ex_rs1_br_offset;
    logic [REG_LEN-1:0]       ex_rs1_data;
    logic [REG_LEN-1:0]       ex_rs2_data;
    logic                     ex_rd_data_use_alu;
    logic                     ex_is_br;
    logic [REG_LEN-1:0]       ex_mem_data;
    logic [MEMD_SIZE_LOG-1:0] ex_mem_addr;
    logic [REG_LEN-1:0]       ex_rd_data;
    logic                     ex_taken;
    logic [MEMI_SIZE_LOG-1:0] ex_next_pc;

    modport master (
        output req_addr,
        input  resp_data,
        input  opcode, rs1_used, rs1_imm, rs1_br_offset, rs1, rs2_used, rs2,
        input  wen, rd, rd_data_use_alu, mem_valid, is_br,
        output ex_pc, ex_op, ex_rs1_imm, ex_rs1_br_offset, ex_rs1_data, ex_rs2_data,
        output ex_rd_data_use_alu, ex_is_br, ex_mem_data,
        input  ex_mem_addr, ex_rd_data, ex_taken, ex_next_pc
    );

    modport slave (
        input  req_addr,
        output resp_data,
        output opcode, rs1_used, rs1_imm, rs1_br_offset, rs1, rs2_used, rs2,
        output wen, rd, rd_data_use_alu, mem_valid, is_br,
        input  ex_pc, ex_op, ex_rs1_imm, ex_rs1_br_offset, ex_rs1_data, ex_rs2_data,
        input  ex_rd_data_use_alu, ex_is_br, ex_mem_data,
        output ex_mem_addr, ex_rd_data, ex_taken, ex_next_pc
    );

endinterface

// File: rtl/isa_fetch_decode_exec_decode.sv
// Instruction decoder: field extraction plus per-opcode control flags.
module isa_fetch_decode_exec_decode
    import isa_fetch_decode_exec_pkg::*;
(
    input  logic [INST_LEN-1:0]      inst,
    output logic [INST_SIZE_LOG-1:0] opcode,
    output logic                     rs1_used,
    output logic [REG_LEN-1:0]       rs1_imm,
    output logic [MEMI_SIZE_LOG-1:0] rs1_br_offset,
    output logic [RF_SIZE_LOG-1:0]   rs1,
    output logic                     rs2_used,
    output logic [RF_SIZE_LOG-1:0]   rs2,
    output logic                     wen,
    output logic [RF_SIZE_LOG-1:0]   rd,
    output logic                     rd_data_use_alu,
    output logic                     mem_valid,
    output logic                     is_br
);

    inst_t f;
    logic  is_li, is_add, is_mul, is_ld;

    assign f = inst_t'(inst);

    // Fields are passed through regardless of opcode; rs1 and branch offset alias the imm field.
    assign opcode        = f.op;
    assign rd            = f.rd;
    assign rs2           = f.rs2;
    assign rs1_imm       = f.imm;
    assign rs1           = f.imm[RF_SIZE_LOG-1:0];
    assign rs1_br_offset = f.imm[MEMI_SIZE_LOG-1:0];

    // Opcodes 6 and 7 match nothing and therefore decode as NOP.
    always_comb begin
        is_li           = (f.op == INST_OP_LI);
        is_add          = (f.op == INST_OP_ADD);
        is_mul          = (f.op == INST_OP_MUL);
        is_ld           = (f.op == INST_OP_LD);
        is_br           = (f.op == INST_OP_BR);
        wen             = is_li | is_add | is_mul | is_ld;
        rs1_used        = is_add | is_mul | is_ld;
        rs2_used        = is_add | is_mul | is_br;
        mem_valid       = is_ld;
        rd_data_use_alu = !is_ld;
    end

endmodule

// File: rtl/isa_fetch_decode_exec_execute.sv
// Per-ROB-entry execute unit: ALU, load address and branch resolution.
module isa_fetch_decode_exec_execute
    import isa_fetch_decode_exec_pkg::*;
(
    input  logic [MEMI_SIZE_LOG-1:0] ex_pc,
    input  logic [INST_SIZE_LOG-1:0] ex_op,
    input  logic [REG_LEN-1:0]       ex_rs1_imm,
    input  logic [MEMI_SIZE_LOG-1:0] ex_rs1_br_offset,
    input  logic [REG_LEN-1:0]       ex_rs1_data,
    input  logic [REG_LEN-1:0]       ex_rs2_data,
    input  logic                     ex_rd_data_use_alu,
    input  logic                     ex_is_br,
    input  logic [REG_LEN-1:0]       ex_mem_data,
    output logic [MEMD_SIZE_LOG-1:0] ex_mem_addr,
    output logic [REG_LEN-1:0]       ex_rd_data,
    output logic                     ex_taken,
    output logic [MEMI_SIZE_LOG-1:0] ex_next_pc
);

    logic [REG_LEN-1:0] alu;

    // ALU result; arithmetic wraps at REG_LEN bits, MUL keeps the low half.
    always_comb begin
        alu = '0;
        case (ex_op)
            INST_OP_LI:  alu = ex_rs1_imm;
            INST_OP_ADD: alu = ex_rs1_data + ex_rs2_data;
            INST_OP_MUL: alu = ex_rs1_data * ex_rs2_data;
            default:     alu = '0;
        endcase
    end

    // Load address, writeback select and branch resolution; PC arithmetic wraps.
    always_comb begin
        ex_mem_addr = '0;
        if (ex_op == INST_OP_LD) begin
            ex_mem_addr = ex_rs1_data[MEMD_SIZE_LOG-1:0];
        end
        ex_rd_data = ex_rd_data_use_alu ? alu : ex_mem_data;
        ex_taken   = ex_is_br && (ex_rs2_data == '0);
        ex_next_pc = ex_taken ? (ex_pc + ex_rs1_br_offset) : (ex_pc + MEMI_SIZE_LOG'(1));
    end

endmodule

// File: rtl/isa_fetch_decode_exec_memi.sv
// Instruction ROM: boot image loaded on reset, asynchronous read.
module isa_fetch_decode_exec_memi
    import isa_fetch_decode_exec_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MEMI_SIZE_LOG-1:0] req_addr,
    output logic [INST_LEN-1:0]      resp_data
);

    logic [INST_LEN-1:0] array [MEMI_SIZE];

    // Reload the boot program whenever reset is sampled high; otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEMI_SIZE; i++) begin
                array[i] <= rom_word(i);
            end
        end
    end

    assign resp_data = array[req_addr];

endmodule

// File: rtl/isa_fetch_decode_exec.sv
// Wrapper exposing instruction ROM, decoder and execute unit; ROM output feeds the decoder.
module isa_fetch_decode_exec
    import isa_fetch_decode_exec_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    isa_fetch_decode_exec_if.slave bus
);

    isa_fetch_decode_exec_memi memi_instance (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (bus.req_addr),
        .resp_data (bus.resp_data)
    );

    isa_fetch_decode_exec_decode decode_instance (
        .inst            (bus.resp_data),
        .opcode          (bus.opcode),
        .rs1_used        (bus.rs1_used),
        .rs1_imm         (bus.rs1_imm),
        .rs1_br_offset   (bus.rs1_br_offset),
        .rs1             (bus.rs1),
        .rs2_used        (bus.rs2_used),
        .rs2             (bus.rs2),
        .wen             (bus.wen),
        .rd              (bus.rd),
        .rd_data_use_alu (bus.rd_data_use_alu),
        .mem_valid       (bus.mem_valid),
        .is_br           (bus.is_br)
    );

    isa_fetch_decode_exec_execute execute_instance (
        .ex_pc              (bus.ex_pc),
        .ex_op              (bus.ex_op),
        .ex_rs1_imm         (bus.ex_rs1_imm),
        .ex_rs1_br_offset   (bus.ex_rs1_br_offset),
        .ex_rs1_data        (bus.ex_rs1_data),
        .ex_rs2_data        (bus.ex_rs2_data),
        .ex_rd_data_use_alu (bus.ex_rd_data_use_alu),
        .ex_is_br           (bus.ex_is_br),
        .ex_mem_data        (bus.ex_mem_data),
        .ex_mem_addr        (bus.ex_mem_addr),
        .ex_rd_data         (bus.ex_rd_data),
        .ex_taken           (bus.ex_taken),
        .ex_next_pc         (bus.ex_next_pc)
    );

endmodule

// File: tb/tb_isa_fetch_decode_exec.sv
// Directed table-driven bench for ROM contents, decode fields and execute results.
module tb_isa_fetch_decode_exec;
    import isa_fetch_decode_exec_pkg::*;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    isa_fetch_decode_exec_if bus ();

    isa_fetch_decode_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [10:0] inst;
        logic [2:0]  op;
        logic [1:0]  rd;
        logic [1:0]  rs1;
        logic [1:0]  rs2;
        logic [3:0]  imm;
        logic [2:0]  off;
        logic        wen;
        logic        rs1u;
        logic        rs2u;
        logic        mem;
        logic        br;
        logic        alu;
    } dec_vec_t;

    typedef struct {
        string       name;
        logic [2:0]  pc;
        logic [2:0]  op;
        logic [3:0]  imm;
        logic [2:0]  off;
        logic [3:0]  rs1d;
        logic [3:0]  rs2d;
        logic        use_alu;
        logic        is_br;
        logic [3:0]  memd;
        logic [1:0]  x_maddr;
        logic [3:0]  x_rd;
        logic        x_taken;
        logic [2:0]  x_npc;
    } ex_vec_t;

    dec_vec_t dv [8];
    ex_vec_t  ev [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_decode(input int i);
        string t;
        t = $sformatf("a%0d", dv[i].addr);
        chk({t, " resp_data"},       32'(bus.resp_data),       32'(dv[i].inst));
        chk({t, " opcode"},          32'(bus.opcode),          32'(dv[i].op));
        chk({t, " rd"},              32'(bus.rd),              32'(dv[i].rd));
        chk({t, " rs1"},             32'(bus.rs1),             32'(dv[i].rs1));
        chk({t, " rs2"},             32'(bus.rs2),             32'(dv[i].rs2));
        chk({t, " rs1_imm"},         32'(bus.rs1_imm),         32'(dv[i].imm));
        chk({t, " rs1_br_offset"},   32'(bus.rs1_br_offset),   32'(dv[i].off));
        chk({t, " wen"},             32'(bus.wen),             32'(dv[i].wen));
        chk({t, " rs1_used"},        32'(bus.rs1_used),        32'(dv[i].rs1u));
        chk({t, " rs2_used"},        32'(bus.rs2_used),        32'(dv[i].rs2u));
        chk({t, " mem_valid"},       32'(bus.mem_valid),       32'(dv[i].mem));
        chk({t, " is_br"},           32'(bus.is_br),           32'(dv[i].br));
        chk({t, " rd_data_use_alu"}, 32'(bus.rd_data_use_alu), 32'(dv[i].alu));
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        //            addr  inst    op rd rs1 rs2 imm off wen r1u r2u mem br alu
        dv[0] = '{3'd0, 11'h148, 3'd1, 2'd1, 2'd2, 2'd0, 4'd2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        dv[1] = '{3'd1, 11'h484, 3'd4, 2'd2, 2'd1, 2'd0, 4'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        dv[2] = '{3'd2, 11'h2C6, 3'd2, 2'd3, 2'd1, 2'd2, 4'd1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        dv[3] = '{3'd3, 11'h508, 3'd5, 2'd0, 2'd2, 2'd0, 4'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 4; i < 8; i++) begin
            dv[i] = '{3'(i), 11'h000, 3'd0, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        end

        //        name        pc    op    imm   off   rs1d  rs2d  alu  br   memd   maddr rd    tkn  npc
        ev[0]  = '{"add_wrap", 3'd0, 3'd2, 4'h0, 3'd0, 4'h9, 4'h9, 1'b1, 1'b0, 4'h0, 2'd0, 4'h2, 1'b0, 3'd1};
        ev[1]  = '{"mul_3x6",  3'd2, 3'd3, 4'h0, 3'd0, 4'h3, 4'h6, 1'b1, 1'b0, 4'h0, 2'd0, 4'h2, 1'b0, 3'd3};
        ev[2]  = '{"li",       3'd5, 3'd1, 4'hA, 3'd0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 2'd0, 4'hA, 1'b0, 3'd6};
        ev[3]  = '{"ld",       3'd3, 3'd4, 4'h0, 3'd0, 4'hE, 4'h0, 1'b0, 1'b0, 4'h7, 2'd2, 4'h7, 1'b0, 3'd4};
        ev[4]  = '{"br_taken", 3'd7, 3'd5, 4'h0, 3'd2, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 2'd0, 4'h0, 1'b1, 3'd1};
        ev[5]  = '{"br_not",   3'd7, 3'd5, 4'h0, 3'd2, 4'h0, 4'h1, 1'b1, 1'b1, 4'h0, 2'd0, 4'h0, 1'b0, 3'd0};
        ev[6]  = '{"nop",      3'd4, 3'd0, 4'h5, 3'd1, 4'h5, 4'h3, 1'b1, 1'b0, 4'h9, 2'd0, 4'h0, 1'b0, 3'd5};
        ev[7]  = '{"op6",      3'd1, 3'd6, 4'h5, 3'd1, 4'h5, 4'h3, 1'b1, 1'b0, 4'h9, 2'd0, 4'h0, 1'b0, 3'd2};
        ev[8]  = '{"op7",      3'd6, 3'd7, 4'h5, 3'd1, 4'h5, 4'h3, 1'b1, 1'b0, 4'h9, 2'd0, 4'h0, 1'b0, 3'd7};
        ev[9]  = '{"add_naddr",3'd1, 3'd2, 4'h0, 3'd0, 4'hF, 4'h1, 1'b1, 1'b0, 4'h0, 2'd0, 4'h0, 1'b0, 3'd2};
        ev[10] = '{"br_off0",  3'd4, 3'd5, 4'h0, 3'd0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h0, 2'd0, 4'h0, 1'b1, 3'd4};
        ev[11] = '{"mul_ff",   3'd7, 3'd3, 4'h0, 3'd0, 4'hF, 4'hF, 1'b1, 1'b0, 4'h0, 2'd0, 4'h1, 1'b0, 3'd0};

        rst                    = 1'b1;
        bus.req_addr           = '0;
        bus.ex_pc              = '0;
        bus.ex_op              = '0;
        bus.ex_rs1_imm         = '0;
        bus.ex_rs1_br_offset   = '0;
        bus.ex_rs1_data        = '0;
        bus.ex_rs2_data        = '0;
        bus.ex_rd_data_use_alu = 1'b0;
        bus.ex_is_br           = 1'b0;
        bus.ex_mem_data        = '0;

        @(posedge clk);
        #1 rst = 1'b0;

        // ROM contents and decode of every address after reset.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.req_addr = dv[i].addr;
            #1 check_decode(i);
        end

        // Execute vectors.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bus.ex_pc              = ev[i].pc;
            bus.ex_op              = ev[i].op;
            bus.ex_rs1_imm         = ev[i].imm;
            bus.ex_rs1_br_offset   = ev[i].off;
            bus.ex_rs1_data        = ev[i].rs1d;
            bus.ex_rs2_data        = ev[i].rs2d;
            bus.ex_rd_data_use_alu = ev[i].use_alu;
            bus.ex_is_br           = ev[i].is_br;
            bus.ex_mem_data        = ev[i].memd;
            #1;
            chk({ev[i].name, " ex_mem_addr"}, 32'(bus.ex_mem_addr), 32'(ev[i].x_maddr));
            chk({ev[i].name, " ex_rd_data"},  32'(bus.ex_rd_data),  32'(ev[i].x_rd));
            chk({ev[i].name, " ex_taken"},    32'(bus.ex_taken),    32'(ev[i].x_taken));
            chk({ev[i].name, " ex_next_pc"},  32'(bus.ex_next_pc),  32'(ev[i].x_npc));
        end

        // ROM read is asynchronous: several address changes within one clock phase.
        @(negedge clk);
        bus.req_addr = 3'd2;
        #1 chk("async a2", 32'(bus.resp_data), 32'h2C6);
        bus.req_addr = 3'd3;
        #1 chk("async a3", 32'(bus.resp_data), 32'h508);
        bus.req_addr = 3'd0;
        #1 chk("async a0", 32'(bus.resp_data), 32'h148);

        // Contents hold across idle cycles, and a second reset reloads the same image.
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.req_addr = 3'd1;
        #1 chk("hold a1", 32'(bus.resp_data), 32'h484);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.req_addr = dv[i].addr;
            #1 chk($sformatf("rereset a%0d", i), 32'(bus.resp_data), 32'(dv[i].inst));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
